tdm_demux: RTL
==============

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter LANES, default 4, the number of output lanes per frame (legal 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port din  input  1  time-multiplexed serial sample.
REQ-005 SHALL have port din_valid  input  1  din carries a sample this cycle.
REQ-006 SHALL have port sof  input  1  start-of-frame; qualified by din_valid, marks the lane-0 sample.
REQ-007 SHALL have port lanes  output  LANES  demultiplexed frame; bit k = k-th sample after sof, inclusive.
REQ-008 SHALL have port out_valid  output  1  lanes holds a complete frame.
REQ-009 SHALL have port out_ready  input  1  consumer accepts lanes when out_valid=1.
REQ-010 SHALL have port overrun  output  1  sticky; sample dropped while the frame was held.
REQ-011 SHALL have port sync_err  output  1  sticky; sof received mid-frame.
REQ-012 SHALL have port parity_err  output  1  frame parity mismatch (see Configuration).

Function
REQ-013 SHALL implement states IDLE, COLLECT, HOLD with a lane counter of width clog2(LANES).
REQ-014 IDLE: din_valid=1 and sof=1 SHALL capture din into the lane-0 shadow, set cnt=1 and go to COLLECT; din_valid without sof SHALL be ignored.
REQ-015 COLLECT: each din_valid with sof=0 SHALL capture din into shadow bit cnt and increment cnt.
REQ-016 When the final sample of a frame is captured, the shadow SHALL be copied to lanes and out_valid SHALL be 1 from the next cycle, in state HOLD; latency from final sample to out_valid is 1 cycle.
REQ-017 COLLECT with din_valid=1 and sof=1 SHALL restart the frame (sample to lane 0, cnt=1) and set sync_err.
REQ-018 HOLD: lanes and out_valid SHALL stay stable until out_valid=1 and out_ready=1 in the same cycle; the state then goes to IDLE and out_valid=0 next cycle.
REQ-019 HOLD: din_valid=1 with out_ready=0 SHALL drop the sample and set overrun.
REQ-020 HOLD: out_ready=1 together with din_valid=1 and sof=1 SHALL complete the handshake and start a new frame as in REQ-014, with no overrun.
REQ-021 HOLD: out_ready=1 together with din_valid=1 and sof=0 SHALL complete the handshake and drop the sample without setting overrun.
REQ-022 din_valid=0 SHALL never change cnt or shadow; gaps between samples of any length SHALL be tolerated.
REQ-023 overrun and sync_err SHALL clear only on reset.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE, cnt=0, shadow=0, lanes=0, out_valid=0, overrun=0, sync_err=0, parity_err=0.
REQ-025 Reset during COLLECT or HOLD SHALL discard the partial or held frame; the first frame accepted after release needs a fresh sof.

Configuration
REQ-026 Macro TDM_DEMUX_PARITY_EN defined: each frame SHALL be LANES+1 samples, the last being an even-parity bit over the lanes. parity_err SHALL equal the mismatch, updated with lanes and held through HOLD. The parity bit SHALL not appear in lanes.
REQ-027 Macro TDM_DEMUX_PARITY_EN undefined: each frame SHALL be LANES samples and parity_err SHALL be held at 0.

Verification (LANES=4, parity off unless stated)
REQ-028 Samples 1(sof),0,1,1 back-to-back, out_ready=1 -> lanes=4'b1101, out_valid high 1 cycle after the 4th sample, overrun=0.
REQ-029 Same frame with 3 idle cycles between samples, out_ready=0 for 5 cycles, then 1 -> lanes stable 4'b1101 for the whole hold, out_valid drops the cycle after the handshake.
REQ-030 Frame held, out_ready=0, extra din_valid -> overrun=1 and stays 1; lanes unchanged.
REQ-031 Samples 1(sof),1, then sof with din=0, then 0,1,1 -> sync_err=1, lanes=4'b1100.
REQ-032 Held frame with out_ready=1, din_valid=1 and sof=1 in the same cycle -> handshake completes and the new frame's lane 0 is captured; overrun=0.
REQ-033 rst pulse mid-COLLECT then 1(sof),1,1,1 -> all outputs 0 during reset, then lanes=4'b1111. With parity on, frame 1,0,1,1 and parity bit 0 -> parity_err=1; parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: collects LANES time-slotted samples per frame and holds the frame until it is accepted.
// Optional trailing even-parity bit per frame when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux #(
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [LANES-1:0] lanes,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             sync_err,
  output logic             parity_err
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [LANES-1:0] shadow, shadow_nxt, lanes_nxt;
  logic             overrun_nxt, sync_err_nxt;

`ifdef TDM_DEMUX_PARITY_EN
  // par_wait: all lanes captured, the next sample is the parity bit.
  logic par_wait, par_wait_nxt, parity_err_nxt;

  function automatic logic even_parity_err(input logic [LANES-1:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  assign out_valid = (state == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shadow   <= '0;
      lanes    <= '0;
      overrun  <= 1'b0;
      sync_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_wait   <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shadow   <= shadow_nxt;
      lanes    <= lanes_nxt;
      overrun  <= overrun_nxt;
      sync_err <= sync_err_nxt;
`ifdef TDM_DEMUX_PARITY_EN
      par_wait   <= par_wait_nxt;
      parity_err <= parity_err_nxt;
`endif
    end
  end

`ifndef TDM_DEMUX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shadow_nxt   = shadow;
    lanes_nxt    = lanes;
    overrun_nxt  = overrun;
    sync_err_nxt = sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    par_wait_nxt   = par_wait;
    parity_err_nxt = parity_err;
`endif
    case (state)
      ST_IDLE: begin
        if (din_valid && sof) begin
          shadow_nxt[0] = din;
          cnt_nxt       = CNT_W'(1);
          state_nxt     = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (din_valid) begin
          if (sof) begin
            shadow_nxt[0] = din;
            cnt_nxt       = CNT_W'(1);
            sync_err_nxt  = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
            par_wait_nxt  = 1'b0;
          end else if (par_wait) begin
            lanes_nxt      = shadow;
            parity_err_nxt = even_parity_err(shadow, din);
            par_wait_nxt   = 1'b0;
            state_nxt      = ST_HOLD;
          end else begin
            shadow_nxt[cnt] = din;
            if (cnt == LAST) begin
              cnt_nxt      = '0;
              par_wait_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
`else
          end else begin
            shadow_nxt[cnt] = din;
            if (cnt == LAST) begin
              lanes_nxt = shadow_nxt;
              cnt_nxt   = '0;
              state_nxt = ST_HOLD;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
`endif
        end
      end
      ST_HOLD: begin
        // A sample arriving on the handshake cycle is only kept if it opens a new frame.
        if (out_ready) begin
          state_nxt = ST_IDLE;
          if (din_valid && sof) begin
            shadow_nxt[0] = din;
            cnt_nxt       = CNT_W'(1);
            state_nxt     = ST_COLLECT;
          end
        end else if (din_valid) begin
          overrun_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
